// File: rtl/fft_pkg.sv
// Shared definitions for the in-place radix-2 FFT RAM controller.
// Holds the FSM encoding, default geometry and the bit-reverse helper.
package fft_pkg;

  localparam int unsigned NDefault     = 512;
  localparam int unsigned LMaxDefault  = 9;
  localparam int unsigned BfLatDefault = 3;

  typedef enum logic [2:0] {
    Idle  = 3'd0,
    Read  = 3'd1,
    Drain = 3'd2,
    Out   = 3'd3,
    Fin   = 3'd4
  } ctrl_state_e;

  // Reverses the low w bits of v; bits at and above w are returned as zero.
  function automatic logic [15:0] bit_rev(input logic [15:0] v, input int unsigned w);
    logic [15:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < w) begin
        r[i] = v[4'(w - 1 - i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift pipeline carrying {valid, add1, add2} from the read issue
// to the matching butterfly write-back.
module fft_addr_delay #(
  parameter int unsigned Depth = 3,
  parameter int unsigned AddrW = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [AddrW-1:0] i_add1,
  input  logic [AddrW-1:0] i_add2,
  output logic             o_valid,
  output logic [AddrW-1:0] o_add1,
  output logic [AddrW-1:0] o_add2
);

  localparam int unsigned W = 1 + 2 * AddrW;

  logic [W-1:0] r_pipe [Depth];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= {i_valid, i_add1, i_add2};
      for (int i = 1; i < int'(Depth); i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_valid = r_pipe[Depth-1][W-1];
  assign o_add1  = r_pipe[Depth-1][2*AddrW-1:AddrW];
  assign o_add2  = r_pipe[Depth-1][AddrW-1:0];

endmodule

// File: rtl/fft_ram_ctrl.sv
// In-place radix-2 DIT FFT RAM sequencer: per-stage butterfly read/write-back
// addressing, drain between stages, then a linear result readout.
module fft_ram_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned N      = NDefault,
  parameter int unsigned L_max  = LMaxDefault,
  parameter int unsigned BF_LAT = BfLatDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             rd_en,
  output logic [L_max-1:0] rd_add1,
  output logic [L_max-1:0] rd_add2,
  output logic [L_max-2:0] tw_addr,
  output logic             wr_en,
  output logic [L_max-1:0] wr_add1,
  output logic [L_max-1:0] wr_add2,
  output logic [L_max-1:0] read_addr,
  output logic             out_valid,
  output logic             wd_finish,
  output logic             busy,
  output logic [3:0]       stage
);

  localparam logic [L_max-1:0] KLastRead = L_max'(N / 2 - 1);
  localparam logic [L_max-1:0] KLastOut  = L_max'(N - 1);
  localparam logic [3:0]       SLast     = 4'(L_max - 1);
  localparam logic [2:0]       DLast     = 3'(BF_LAT - 1);

  ctrl_state_e      r_state, w_state_nxt;
  logic [L_max-1:0] r_k, w_k_nxt;
  logic [3:0]       r_s, w_s_nxt;
  logic [2:0]       r_dcnt, w_dcnt_nxt;
  logic             r_out_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= Idle;
      r_k         <= '0;
      r_s         <= '0;
      r_dcnt      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_s         <= w_s_nxt;
      r_dcnt      <= w_dcnt_nxt;
      r_out_valid <= (r_state == Out);
    end
  end

  // k is reused as the butterfly index in Read and the readout address in Out.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_s_nxt     = r_s;
    w_dcnt_nxt  = r_dcnt;
    unique case (r_state)
      Idle: begin
        if (start) begin
          w_state_nxt = Read;
          w_k_nxt     = '0;
          w_s_nxt     = '0;
        end
      end
      Read: begin
        if (r_k == KLastRead) begin
          w_state_nxt = Drain;
          w_dcnt_nxt  = '0;
        end else begin
          w_k_nxt = r_k + 1'b1;
        end
      end
      Drain: begin
        if (r_dcnt == DLast) begin
          w_k_nxt = '0;
          if (r_s < SLast) begin
            w_state_nxt = Read;
            w_s_nxt     = r_s + 4'd1;
          end else begin
            w_state_nxt = Out;
          end
        end else begin
          w_dcnt_nxt = r_dcnt + 3'd1;
        end
      end
      Out: begin
        if (r_k == KLastOut) begin
          w_state_nxt = Fin;
        end else begin
          w_k_nxt = r_k + 1'b1;
        end
      end
      Fin: begin
        w_state_nxt = Idle;
        w_k_nxt     = '0;
        w_s_nxt     = '0;
      end
      default: begin
        w_state_nxt = Idle;
      end
    endcase
  end

  logic [L_max-1:0] w_half, w_grp, w_pos, w_add1, w_add2;
  logic [L_max-2:0] w_tw;
  logic             w_in_read, w_in_out;

  // pos < 2^s <= N/2 while reading, so it fits the twiddle index width.
  always_comb begin
    w_half = L_max'(1) << r_s;
    w_grp  = r_k >> r_s;
    w_pos  = r_k & (w_half - L_max'(1));
    w_add1 = (w_grp << (r_s + 4'd1)) | w_pos;
    w_add2 = w_add1 + w_half;
    w_tw   = w_pos[L_max-2:0] << (SLast - r_s);
  end

  assign w_in_read = (r_state == Read);
  assign w_in_out  = (r_state == Out);

  assign rd_en     = w_in_read | w_in_out;
  assign rd_add1   = w_in_read ? w_add1 : '0;
  assign rd_add2   = w_in_read ? w_add2 : '0;
  assign tw_addr   = w_in_read ? w_tw : '0;
  assign read_addr = w_in_out ? r_k : '0;
  assign out_valid = r_out_valid;
  assign wd_finish = (r_state == Fin);
  assign busy      = (r_state != Idle);
  assign stage     = r_s;

  // Only butterfly reads enter the pipeline, so readout never produces wr_en.
  fft_addr_delay #(
    .Depth (BF_LAT),
    .AddrW (L_max)
  ) u_addr_delay (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_in_read),
    .i_add1  (rd_add1),
    .i_add2  (rd_add2),
    .o_valid (wr_en),
    .o_add1  (wr_add1),
    .o_add2  (wr_add2)
  );

endmodule

// File: tb/tb_fft_ram_ctrl.sv
// Directed bench for fft_ram_ctrl at N=8: per-cycle address/strobe checks
// against hand-derived stage tables, restart, re-pulse and mid-run reset.
module tb_fft_ram_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned LM = 3;
  localparam int unsigned BL = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          rd_en, wr_en, out_valid, wd_finish, busy;
  logic [LM-1:0] rd_add1, rd_add2, wr_add1, wr_add2, read_addr;
  logic [LM-2:0] tw_addr;
  logic [3:0]    stage;

  int n_checks = 0;
  int n_fail   = 0;

  // Butterfly pairs and twiddles for stages 0,1,2 in issue order.
  int a1_tab [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int a2_tab [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int tw_tab [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  always #5 clk = ~clk;

  fft_ram_ctrl #(
    .N      (N),
    .L_max  (LM),
    .BF_LAT (BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_en     (rd_en),
    .rd_add1   (rd_add1),
    .rd_add2   (rd_add2),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_add1   (wr_add1),
    .wr_add2   (wr_add2),
    .read_addr (read_addr),
    .out_valid (out_valid),
    .wd_finish (wd_finish),
    .busy      (busy),
    .stage     (stage)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".rd_en"},     32'(rd_en),     32'd0);
    check_eq({tag, ".rd_add1"},   32'(rd_add1),   32'd0);
    check_eq({tag, ".rd_add2"},   32'(rd_add2),   32'd0);
    check_eq({tag, ".tw_addr"},   32'(tw_addr),   32'd0);
    check_eq({tag, ".wr_en"},     32'(wr_en),     32'd0);
    check_eq({tag, ".wr_add1"},   32'(wr_add1),   32'd0);
    check_eq({tag, ".wr_add2"},   32'(wr_add2),   32'd0);
    check_eq({tag, ".read_addr"}, 32'(read_addr), 32'd0);
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".wd_finish"}, 32'(wd_finish), 32'd0);
    check_eq({tag, ".busy"},      32'(busy),      32'd0);
    check_eq({tag, ".stage"},     32'(stage),     32'd0);
  endtask

  // Entered on a negedge; t=0 is the first read cycle. Stages take 4 read +
  // 3 drain cycles, readout runs t=21..28, FIN at t=29, idle at t=30.
  task automatic run_seq(input int repulse_t, input int abort_t);
    int first_rd;
    int last_wr;
    int n_ov;
    int n_fin;
    int t_end;
    first_rd = -1;
    last_wr  = -1;
    n_ov     = 0;
    n_fin    = 0;
    t_end    = (abort_t >= 0) ? abort_t : 30;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t <= t_end; t++) begin
      int e_rd, e_ov, e_fin, e_busy, e_stage, ri, wi;
      e_rd = 0;
      ri   = -1;
      wi   = -1;
      if (t < 21) begin
        if (t % 7 < 4) begin
          e_rd = 1;
          ri   = (t / 7) * 4 + t % 7;
        end
      end else if (t < 29) begin
        e_rd = 1;
      end
      if (t >= 3 && t - 3 < 21 && (t - 3) % 7 < 4) wi = ((t - 3) / 7) * 4 + (t - 3) % 7;
      e_ov    = (t >= 22 && t <= 29) ? 1 : 0;
      e_fin   = (t == 29) ? 1 : 0;
      e_busy  = (t <= 29) ? 1 : 0;
      e_stage = (t < 21) ? t / 7 : ((t <= 29) ? 2 : 0);

      check_eq($sformatf("rd_en@%0d", t),     32'(rd_en),     32'(e_rd));
      check_eq($sformatf("wr_en@%0d", t),     32'(wr_en),     32'(wi >= 0));
      check_eq($sformatf("out_valid@%0d", t), 32'(out_valid), 32'(e_ov));
      check_eq($sformatf("wd_finish@%0d", t), 32'(wd_finish), 32'(e_fin));
      check_eq($sformatf("busy@%0d", t),      32'(busy),      32'(e_busy));
      check_eq($sformatf("stage@%0d", t),     32'(stage),     32'(e_stage));
      if (ri >= 0) begin
        check_eq($sformatf("rd_add1@%0d", t), 32'(rd_add1), 32'(a1_tab[ri]));
        check_eq($sformatf("rd_add2@%0d", t), 32'(rd_add2), 32'(a2_tab[ri]));
        check_eq($sformatf("tw_addr@%0d", t), 32'(tw_addr), 32'(tw_tab[ri]));
      end
      if (wi >= 0) begin
        check_eq($sformatf("wr_add1@%0d", t), 32'(wr_add1), 32'(a1_tab[wi]));
        check_eq($sformatf("wr_add2@%0d", t), 32'(wr_add2), 32'(a2_tab[wi]));
      end
      if (t >= 21 && t <= 28) begin
        check_eq($sformatf("read_addr@%0d", t),   32'(read_addr), 32'(t - 21));
        check_eq($sformatf("out_rd_add1@%0d", t), 32'(rd_add1),   32'd0);
        check_eq($sformatf("out_rd_add2@%0d", t), 32'(rd_add2),   32'd0);
      end
      if (rd_en && first_rd < 0) first_rd = t;
      if (wr_en) last_wr = t;
      n_ov  += int'(out_valid);
      n_fin += int'(wd_finish);
      if (t < t_end) begin
        start = (t == repulse_t);
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (abort_t < 0) begin
      check_eq("xform_span",      32'(last_wr - first_rd + 1), 32'd21);
      check_eq("out_valid_count", 32'(n_ov),                   32'd8);
      check_eq("wd_finish_count", 32'(n_fin),                  32'd1);
    end
  endtask

  initial begin
    #3;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset_hold");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    run_seq(-1, -1);
    // start one cycle after FIN
    run_seq(-1, -1);
    // stray start during stage 1
    run_seq(8, -1);

    run_seq(-1, 9);
    #2 rst = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk);
    check_all_zero("abort_hold");
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq($sformatf("post_abort_wr_en@%0d", i),     32'(wr_en),     32'd0);
      check_eq($sformatf("post_abort_wd_finish@%0d", i), 32'(wd_finish), 32'd0);
      check_eq($sformatf("post_abort_busy@%0d", i),      32'(busy),      32'd0);
    end
    run_seq(-1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_ram_ctrl.md
FFT_RAM_CTRL -- requirements
Module: fft_ram_ctrl

Interface
REQ-001 SHALL have parameter N, default 512: FFT length, power of two, at least 8.
REQ-002 SHALL have parameter L_max, default 9: log2(N), the address width.
REQ-003 SHALL have parameter BF_LAT, default 3: cycles from a read issue to the matching butterfly write-back, 1..7.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-low.
- start  in  1  one-cycle pulse: RAM initialisation complete (driven by initial_flag).
- rd_en  out  1  RAM read enable.
- rd_add1  out  L_max  butterfly upper-leg read address.
- rd_add2  out  L_max  butterfly lower-leg read address.
- tw_addr  out  L_max-1  twiddle ROM index, aligned with rd_en.
- wr_en  out  1  RAM write-back enable.
- wr_add1  out  L_max  upper-leg write address.
- wr_add2  out  L_max  lower-leg write address.
- read_addr  out  L_max  result readout address.
- out_valid  out  1  RAM dataout_re/im holds result word read_addr-1.
- wd_finish  out  1  one-cycle pulse: transform and readout complete, RAM free.
- busy  out  1  high from start acceptance until wd_finish.
- stage  out  4  current butterfly stage, 0..L_max-1.

Function
REQ-005 SHALL use FSM states IDLE, READ, DRAIN, OUT, FIN.
REQ-006 SHALL move IDLE->READ on start=1, with s=0, k=0, busy=1 from the next cycle; start SHALL be ignored in all other states.
REQ-007 In READ, SHALL assert rd_en for exactly N/2 consecutive cycles, with butterfly k=0..N/2-1 on cycle k.
REQ-008 Addressing SHALL follow radix-2 DIT: half=2^s, grp=k>>s, pos=k&(half-1), rd_add1=grp*2*half+pos, rd_add2=rd_add1+half, tw_addr=pos<<(L_max-1-s).
REQ-009 On the cycle with k=N/2-1, SHALL move READ->DRAIN.
REQ-010 wr_en/wr_add1/wr_add2 SHALL equal rd_en/rd_add1/rd_add2 delayed exactly BF_LAT cycles through a shift pipeline.
REQ-011 DRAIN SHALL hold rd_en=0 for BF_LAT cycles so the last write lands before the next stage's first read (no RAW hazard).
REQ-012 After DRAIN: if s<L_max-1, SHALL set s=s+1, k=0 and re-enter READ; otherwise SHALL enter OUT.
REQ-013 In OUT, SHALL assert rd_en for N cycles with read_addr=0..N-1, rd_add1=rd_add2=0 and wr_en=0.
REQ-014 out_valid SHALL be rd_en-in-OUT delayed one cycle (N pulses total).
REQ-015 After the last OUT cycle, SHALL enter FIN for one cycle: wd_finish=1, then busy=0 and return to IDLE.
REQ-016 Total transform time, first read to last write, SHALL be L_max*(N/2+BF_LAT) cycles.
REQ-017 k and s counters SHALL wrap only under FSM control, never by overflow.
REQ-018 wr_en SHALL never be high during OUT, and never on the same cycle as a read of the same address.

Reset
REQ-019 rst low SHALL force IDLE asynchronously and clear counters and the delay pipeline.
REQ-020 All outputs SHALL be 0 during and after reset; a mid-transform reset SHALL abort with no further wr_en and no wd_finish.

Structure
REQ-021 Shared package fft_pkg SHALL hold the FSM state encodings, the default N, L_max and BF_LAT values, and the bit-reverse helper.
REQ-022 The address pipeline SHALL be one sub-module, fft_addr_delay: parameterised depth BF_LAT, carrying {valid, add1, add2}.

Verification (N=8, L_max=3, BF_LAT=3)
REQ-023 start pulse -> stage 0 read pairs (0,1),(2,3),(4,5),(6,7) with tw_addr=0,0,0,0; wr_en follows 3 cycles later with identical pairs.
REQ-024 Stage 1 -> pairs (0,2),(1,3),(4,6),(5,7), tw_addr 0,2,0,2; stage 2 -> pairs (0,4),(1,5),(2,6),(3,7), tw_addr 0,1,2,3.
REQ-025 Full run -> first rd_en to last wr_en spans 21 cycles; then 8 out_valid pulses with read_addr 0..7; then one wd_finish pulse; busy drops the cycle after.
REQ-026 start re-pulsed during stage 1 -> sequence unchanged; start one cycle after FIN -> new transform begins normally.
REQ-027 rst low mid-stage 1 -> all outputs 0 immediately, no wr_en afterwards; a subsequent start runs the full correct sequence.
